// File: rtl/morph_pkg.sv
// Shared constants and helpers for the binary 3x3 morphology block.
package morph_pkg;
  localparam int MODE_ERODE  = 0;
  localparam int MODE_DILATE = 1;
  localparam int DEF_COLS    = 640;
  localparam int DEF_ROWS    = 480;

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/bin_morph3x3_if.sv
// Pixel stream in/out of the morphology filter, with sop/eop/vld sideband.
interface bin_morph3x3_if;
  logic din_sop;
  logic din_eop;
  logic din_vld;
  logic din;
  logic dout_sop;
  logic dout_eop;
  logic dout_vld;
  logic dout;

  modport slave (input din_sop, din_eop, din_vld, din,
                 output dout_sop, dout_eop, dout_vld, dout);
  modport master(output din_sop, din_eop, din_vld, din,
                 input dout_sop, dout_eop, dout_vld, dout);
endinterface

// File: rtl/line_buf_1b.sv
// 1-bit DEPTH-long delay line advanced on en; RAM with read-before-write pointer.
module line_buf_1b
  import morph_pkg::*;
#(
  parameter int DEPTH = DEF_COLS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);
  localparam int AW = clog2(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_addr <= '0;
    else if (en)   r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
  end

  // Contents are never cleared; the border mask hides stale data.
  always_ff @(posedge clk) begin
    if (en) r_mem[r_addr] <= din;
  end

  assign dout = r_mem[r_addr];
endmodule

// File: rtl/bin_morph3x3.sv
// Binary 3x3 erosion/dilation with two line buffers; fixed 2-cycle latency,
// windows touching the top two rows or left two columns forced to 0.
module bin_morph3x3
  import morph_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int MODE = MODE_ERODE
) (
  input  logic           clk,
  input  logic           rst_n,
  bin_morph3x3_if.slave  io
);
  localparam int CW     = clog2(COLS);
  localparam int RW     = clog2(ROWS);
  localparam int STAGES = 2;

  logic [CW-1:0]     r_col, w_col;
  logic [RW-1:0]     r_row, w_row;
  logic              w_lb0, w_lb1;
  logic [2:0][2:0]   r_win;          // [column age][{r2,r1,r0}]
  logic              r_mask;
  logic              w_red;
  logic              r_dout;
  logic [STAGES:1]   r_vld_pipe, r_sop_pipe, r_eop_pipe;

  // A sop pixel sits at (0,0) regardless of where the counters were.
  assign w_col = io.din_sop ? '0 : r_col;
  assign w_row = io.din_sop ? '0 : r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (io.din_vld) begin
      if (w_col == CW'(COLS - 1)) begin
        r_col <= '0;
        r_row <= (w_row == RW'(ROWS - 1)) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  line_buf_1b #(.DEPTH(COLS)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en(io.din_vld), .din(io.din), .dout(w_lb0)
  );
  line_buf_1b #(.DEPTH(COLS)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(io.din_vld), .din(w_lb0), .dout(w_lb1)
  );

  // Stage 1: window and border mask advance only on valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= '0;
      r_mask <= 1'b0;
    end else if (io.din_vld) begin
      r_win  <= {r_win[1:0], {w_lb1, w_lb0, io.din}};
      r_mask <= (w_row < RW'(2)) || (w_col < CW'(2));
    end
  end

  assign w_red = (MODE == MODE_DILATE) ? (|r_win) : (&r_win);

  // Sideband shifts every cycle so latency is independent of gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_sop_pipe <= '0;
      r_eop_pipe <= '0;
      r_dout     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], io.din_vld};
      r_sop_pipe <= {r_sop_pipe[STAGES-1:1], io.din_sop};
      r_eop_pipe <= {r_eop_pipe[STAGES-1:1], io.din_eop};
      r_dout     <= r_vld_pipe[1] & w_red & ~r_mask;
    end
  end

  assign io.dout     = r_dout;
  assign io.dout_vld = r_vld_pipe[STAGES];
  assign io.dout_sop = r_sop_pipe[STAGES];
  assign io.dout_eop = r_eop_pipe[STAGES];
endmodule

// File: tb/tb_bin_morph3x3.sv
// Bench for bin_morph3x3: erosion and dilation instances on a shared stream,
// checked against a frame-image reference model plus per-frame ones counts.
module tb_bin_morph3x3;
  import morph_pkg::*;

  localparam int C = 8;
  localparam int R = 6;
  localparam int N = C * R;

  typedef struct packed {
    logic vld, sop, eop, d0, d1;
  } exp_t;

  typedef struct {
    string name;
    int    kind;   // 0 all ones, 1 single one at (2,3), 2 all zeros
    int    gap;    // 0 none, 1 two idles after each pixel, 2 random idles
    int    e0;     // expected ones, erosion
    int    e1;     // expected ones, dilation
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic t_sop = 1'b0, t_eop = 1'b0, t_vld = 1'b0, t_pix = 1'b0;
  always #5 clk = ~clk;

  bin_morph3x3_if if0();
  bin_morph3x3_if if1();
  assign if0.din_sop = t_sop;
  assign if0.din_eop = t_eop;
  assign if0.din_vld = t_vld;
  assign if0.din     = t_pix;
  assign if1.din_sop = t_sop;
  assign if1.din_eop = t_eop;
  assign if1.din_vld = t_vld;
  assign if1.din     = t_pix;

  bin_morph3x3 #(.COLS(C), .ROWS(R), .MODE(MODE_ERODE))  u_ero (.clk(clk), .rst_n(rst_n), .io(if0));
  bin_morph3x3 #(.COLS(C), .ROWS(R), .MODE(MODE_DILATE)) u_dil (.clk(clk), .rst_n(rst_n), .io(if1));

  int   n_cmp = 0;
  int   n_err = 0;
  int   ones0 = 0;
  int   ones1 = 0;
  int   m_col = 0;
  int   m_row = 0;
  bit   img [R][C];
  exp_t q[$];

  // Reference: keep the current frame as an image, evaluate the 3x3 neighbourhood.
  task automatic model(input logic v, s, e, p, output exp_t x);
    int n1;
    x = '0;
    x.vld = v; x.sop = s; x.eop = e;
    if (v) begin
      if (s) begin m_col = 0; m_row = 0; end
      img[m_row][m_col] = p;
      if (m_row >= 2 && m_col >= 2) begin
        n1 = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            n1 += int'(img[m_row-dr][m_col-dc]);
        x.d0 = (n1 == 9);
        x.d1 = (n1 > 0);
      end
      m_col++;
      if (m_col == C) begin
        m_col = 0;
        m_row = (m_row == R - 1) ? 0 : m_row + 1;
      end
    end
  endtask

  task automatic chk_out();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    if ({if0.dout_vld, if0.dout_sop, if0.dout_eop, if0.dout} !== {e.vld, e.sop, e.eop, e.d0}) begin
      n_err++;
      $display("FAIL ero_out t=%0t got vsep=%b%b%b%b want %b%b%b%b", $time,
               if0.dout_vld, if0.dout_sop, if0.dout_eop, if0.dout, e.vld, e.sop, e.eop, e.d0);
    end
    n_cmp++;
    if ({if1.dout_vld, if1.dout_sop, if1.dout_eop, if1.dout} !== {e.vld, e.sop, e.eop, e.d1}) begin
      n_err++;
      $display("FAIL dil_out t=%0t got vsep=%b%b%b%b want %b%b%b%b", $time,
               if1.dout_vld, if1.dout_sop, if1.dout_eop, if1.dout, e.vld, e.sop, e.eop, e.d1);
    end
    ones0 += int'(if0.dout_vld & if0.dout);
    ones1 += int'(if1.dout_vld & if1.dout);
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if ({if0.dout_vld, if0.dout_sop, if0.dout_eop, if0.dout,
         if1.dout_vld, if1.dout_sop, if1.dout_eop, if1.dout} !== 8'h00) begin
      n_err++;
      $display("FAIL %s got ero=%b%b%b%b dil=%b%b%b%b want all 0", nm,
               if0.dout_vld, if0.dout_sop, if0.dout_eop, if0.dout,
               if1.dout_vld, if1.dout_sop, if1.dout_eop, if1.dout);
    end
  endtask

  task automatic chk_cnt(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s ones got %0d want %0d", nm, got, want);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cyc(input logic v, s, e, p);
    exp_t x;
    t_vld = v; t_sop = s; t_eop = e; t_pix = p;
    model(v, s, e, p, x);
    q.push_back(x);
    @(posedge clk);
    #1;
    chk_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_range(input bit pix [N], input int lo, input int hi,
                             input bit sop_lo, input int gap);
    for (int i = lo; i <= hi; i++) begin
      cyc(1'b1, sop_lo && (i == lo), i == N - 1, pix[i]);
      if (gap == 1) idle(2);
      else if (gap == 2) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic fill(input int kind, output bit pix [N]);
    for (int i = 0; i < N; i++) pix[i] = (kind == 0) || (kind == 1 && i == 2 * C + 3);
  endtask

  task automatic restart_model();
    q.delete();
    q.push_back('0);
    m_col = 0;
    m_row = 0;
  endtask

  vec_t vt [5];
  bit   p [N];
  int   len;

  initial begin
    vt[0] = '{"ones",        0, 0, 24, 24};
    vt[1] = '{"single",      1, 0,  0,  9};
    vt[2] = '{"ones_gap",    0, 1, 24, 24};
    vt[3] = '{"zeros_after", 2, 0,  0,  0};
    vt[4] = '{"single_rgap", 1, 2,  0,  9};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst_n = 1'b1;
    restart_model();
    idle(2);

    foreach (vt[k]) begin
      fill(vt[k].kind, p);
      ones0 = 0; ones1 = 0;
      drive_range(p, 0, N - 1, 1'b1, vt[k].gap);
      idle(2);
      chk_cnt({vt[k].name, "_ero"}, ones0, vt[k].e0);
      chk_cnt({vt[k].name, "_dil"}, ones1, vt[k].e1);
    end

    // Extra sop at pixel 20: two fresh lines must be masked again.
    fill(0, p);
    drive_range(p, 0, 19, 1'b1, 0);
    idle(2);
    ones0 = 0; ones1 = 0;
    drive_range(p, 0, 15, 1'b1, 0);
    idle(2);
    chk_cnt("resop_masked_ero", ones0, 0);
    chk_cnt("resop_masked_dil", ones1, 0);
    ones0 = 0; ones1 = 0;
    drive_range(p, 16, N - 1, 1'b0, 0);
    idle(2);
    chk_cnt("resop_rest_ero", ones0, 24);

    // Asynchronous reset mid-frame, then a clean frame.
    drive_range(p, 0, 19, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_now");
    @(posedge clk);
    #1;
    chk_zero("async_reset_edge");
    rst_n = 1'b1;
    restart_model();
    idle(3);
    ones0 = 0; ones1 = 0;
    drive_range(p, 0, N - 1, 1'b1, 0);
    idle(2);
    chk_cnt("post_reset_ero", ones0, 24);
    chk_cnt("post_reset_dil", ones1, 24);

    // Random images, random gaps, occasional truncated frames.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 4) != 0);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, N - 1)) : N;
      drive_range(p, 0, len - 1, 1'b1, 2);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
